// File: rtl/decode_route_unit.sv
// Control block of the 6502-style core: phase clocks, single-path opcode decode
// with a three-state IDLE/EXEC/DONE sequencer, and a registered 1-to-8 data fan.
module decode_route_unit #(
    parameter int REG_WIDTH = 8,
    parameter int WE_WIDTH  = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 phi1,
    output logic                 phi2,
    input  logic [REG_WIDTH-1:0] instruction_in,
    input  logic                 instruction_ready,
    output logic [REG_WIDTH-1:0] opp,
    output logic [WE_WIDTH-1:0]  we,
    output logic [2:0]           source_selector_0,
    output logic [2:0]           target_selector_0,
    output logic [2:0]           source_selector_1,
    output logic [2:0]           target_selector_1,
    output logic                 instruction_done,
    input  logic [REG_WIDTH-1:0] fan_in,
    output logic [REG_WIDTH-1:0] fan_out0,
    output logic [REG_WIDTH-1:0] fan_out1,
    output logic [REG_WIDTH-1:0] fan_out2,
    output logic [REG_WIDTH-1:0] fan_out3,
    output logic [REG_WIDTH-1:0] fan_out4,
    output logic [REG_WIDTH-1:0] fan_out5,
    output logic [REG_WIDTH-1:0] fan_out6,
    output logic [REG_WIDTH-1:0] fan_out7
);

    localparam int WE_PC   = 0;
    localparam int WE_SP   = 1;
    localparam int WE_ADD  = 2;
    localparam int WE_X    = 3;
    localparam int WE_Y    = 4;
    localparam int WE_STAT = 5;
    localparam int WE_DOUT = 6;

    localparam logic [2:0] SRC_ADD  = 3'd1;
    localparam logic [2:0] SRC_X    = 3'd2;
    localparam logic [2:0] SRC_Y    = 3'd3;
    localparam logic [2:0] SRC_IMM  = 3'd4;
    localparam logic [2:0] SRC_MEM  = 3'd5;
    localparam logic [2:0] SRC_ZERO = 3'd6;

    localparam logic [2:0] TGT_ADD  = 3'd1;
    localparam logic [2:0] TGT_X    = 3'd2;
    localparam logic [2:0] TGT_Y    = 3'd3;
    localparam logic [2:0] TGT_NONE = 3'd4;
    localparam logic [2:0] TGT_MEM  = 3'd5;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef struct packed {
        logic [WE_WIDTH-1:0] we;
        logic [2:0]          src;
        logic [2:0]          tgt;
    } ctrl_t;

    state_t state, state_next;
    ctrl_t  dec;
    logic   accept;
    logic [REG_WIDTH-1:0] fan_q [8];

    assign phi1 = ~clk;
    assign phi2 = clk;

    // Path 1 is reserved and therefore permanently parked at idle.
    assign source_selector_1 = SRC_ZERO;
    assign target_selector_1 = TGT_NONE;

    function automatic ctrl_t decode(input logic [REG_WIDTH-1:0] op);
        ctrl_t d;
        d.we  = '0;
        d.src = SRC_ZERO;
        d.tgt = TGT_NONE;
        case (op)
            8'hA9: begin d.src = SRC_IMM; d.tgt = TGT_ADD; d.we[WE_ADD]  = 1'b1; end
            8'hA5: begin d.src = SRC_MEM; d.tgt = TGT_ADD; d.we[WE_ADD]  = 1'b1; end
            8'hA2: begin d.src = SRC_IMM; d.tgt = TGT_X;   d.we[WE_X]    = 1'b1; end
            8'hA0: begin d.src = SRC_IMM; d.tgt = TGT_Y;   d.we[WE_Y]    = 1'b1; end
            8'h85: begin d.src = SRC_ADD; d.tgt = TGT_MEM; d.we[WE_DOUT] = 1'b1; end
            8'h86: begin d.src = SRC_X;   d.tgt = TGT_MEM; d.we[WE_DOUT] = 1'b1; end
            8'h84: begin d.src = SRC_Y;   d.tgt = TGT_MEM; d.we[WE_DOUT] = 1'b1; end
            8'hAA: begin d.src = SRC_ADD; d.tgt = TGT_X;   d.we[WE_X]    = 1'b1; end
            8'hA8: begin d.src = SRC_ADD; d.tgt = TGT_Y;   d.we[WE_Y]    = 1'b1; end
            8'h8A: begin d.src = SRC_X;   d.tgt = TGT_ADD; d.we[WE_ADD]  = 1'b1; end
            8'h98: begin d.src = SRC_Y;   d.tgt = TGT_ADD; d.we[WE_ADD]  = 1'b1; end
            default: ;  // NOP and undefined opcodes keep the idle control word
        endcase
        return d;
    endfunction

    assign dec    = decode(instruction_in);
    assign accept = (state == IDLE) && instruction_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: the default before the case keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (instruction_ready) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Controls are registered on the accepting edge so they are valid for
    // exactly the EXEC cycle and drop back to idle on the edge that ends it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opp               <= '0;
            we                <= '0;
            source_selector_0 <= SRC_ZERO;
            target_selector_0 <= TGT_NONE;
            instruction_done  <= 1'b0;
        end else begin
            if (accept) begin
                opp               <= instruction_in;
                we                <= dec.we;
                source_selector_0 <= dec.src;
                target_selector_0 <= dec.tgt;
            end else begin
                we                <= '0;
                source_selector_0 <= SRC_ZERO;
                target_selector_0 <= TGT_NONE;
            end
            instruction_done <= (state == EXEC);
        end
    end

    // NOTE: the fan registers are output state, not storage, so each is reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) fan_q[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++)
                fan_q[i] <= (target_selector_0 == 3'(i)) ? fan_in : '0;
        end
    end

    assign fan_out0 = fan_q[0];
    assign fan_out1 = fan_q[1];
    assign fan_out2 = fan_q[2];
    assign fan_out3 = fan_q[3];
    assign fan_out4 = fan_q[4];
    assign fan_out5 = fan_q[5];
    assign fan_out6 = fan_q[6];
    assign fan_out7 = fan_q[7];

    // WE_PC, WE_SP and WE_STAT name bits no current opcode drives.
    logic unused_bits;
    assign unused_bits = ^{WE_PC, WE_SP, WE_STAT};

endmodule

// File: tb/tb_decode_route_unit.sv
// Self-checking bench for decode_route_unit: directed scenarios plus a random run
// against a transaction-level model built from the opcode table.
module tb_decode_route_unit;

    logic       clk;
    logic       reset_n;
    logic       phi1, phi2;
    logic [7:0] instruction_in;
    logic       instruction_ready;
    logic [7:0] opp;
    logic [6:0] we;
    logic [2:0] source_selector_0, target_selector_0;
    logic [2:0] source_selector_1, target_selector_1;
    logic       instruction_done;
    logic [7:0] fan_in;
    logic [7:0] fan_out0, fan_out1, fan_out2, fan_out3;
    logic [7:0] fan_out4, fan_out5, fan_out6, fan_out7;

    int errors = 0;
    int checks = 0;

    decode_route_unit #(.REG_WIDTH(8), .WE_WIDTH(7)) dut (
        .clk(clk), .reset_n(reset_n), .phi1(phi1), .phi2(phi2),
        .instruction_in(instruction_in), .instruction_ready(instruction_ready),
        .opp(opp), .we(we),
        .source_selector_0(source_selector_0), .target_selector_0(target_selector_0),
        .source_selector_1(source_selector_1), .target_selector_1(target_selector_1),
        .instruction_done(instruction_done), .fan_in(fan_in),
        .fan_out0(fan_out0), .fan_out1(fan_out1), .fan_out2(fan_out2), .fan_out3(fan_out3),
        .fan_out4(fan_out4), .fan_out5(fan_out5), .fan_out6(fan_out6), .fan_out7(fan_out7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    // Opcode table: defined flag, source, target and write-enable bit index.
    logic       tbl_def [256];
    logic [2:0] tbl_src [256];
    logic [2:0] tbl_tgt [256];
    int         tbl_bit [256];
    logic [7:0] defined_ops [12];

    // Instruction lifecycle: cycles since acceptance (0 = not busy).
    int         m_age;
    logic [7:0] m_op;
    logic [7:0] m_fan [8];

    task automatic add_op(input int idx, input logic [7:0] op, input logic [2:0] s,
                          input logic [2:0] t, input int b);
        tbl_def[op] = 1'b1; tbl_src[op] = s; tbl_tgt[op] = t; tbl_bit[op] = b;
        defined_ops[idx] = op;
    endtask

    task automatic init_table();
        for (int i = 0; i < 256; i++) begin
            tbl_def[i] = 1'b0; tbl_src[i] = 3'd6; tbl_tgt[i] = 3'd4; tbl_bit[i] = 0;
        end
        add_op(0, 8'hA9, 4, 1, 2);  add_op(1, 8'hA5, 5, 1, 2);
        add_op(2, 8'hA2, 4, 2, 3);  add_op(3, 8'hA0, 4, 3, 4);
        add_op(4, 8'h85, 1, 5, 6);  add_op(5, 8'h86, 2, 5, 6);
        add_op(6, 8'h84, 3, 5, 6);  add_op(7, 8'hAA, 1, 2, 3);
        add_op(8, 8'hA8, 1, 3, 4);  add_op(9, 8'h8A, 2, 1, 2);
        add_op(10, 8'h98, 3, 1, 2);
        defined_ops[11] = 8'hEA;
    endtask

    task automatic model_reset();
        m_age = 0;
        m_op  = 8'h00;
        for (int i = 0; i < 8; i++) m_fan[i] = 8'h00;
    endtask

    function automatic logic [6:0] exp_we();
        if (m_age == 1 && tbl_def[m_op]) return 7'(1 << tbl_bit[m_op]);
        return 7'd0;
    endfunction

    function automatic logic [2:0] exp_src();
        return (m_age == 1) ? tbl_src[m_op] : 3'd6;
    endfunction

    function automatic logic [2:0] exp_tgt();
        return (m_age == 1) ? tbl_tgt[m_op] : 3'd4;
    endfunction

    // {opp, we, src0, tgt0, src1, tgt1, done}
    function automatic logic [27:0] exp_ctrl();
        return {m_op, exp_we(), exp_src(), exp_tgt(), 3'd6, 3'd4, m_age == 2};
    endfunction

    function automatic logic [27:0] dut_ctrl();
        return {opp, we, source_selector_0, target_selector_0,
                source_selector_1, target_selector_1, instruction_done};
    endfunction

    function automatic logic [63:0] exp_fan();
        return {m_fan[7], m_fan[6], m_fan[5], m_fan[4], m_fan[3], m_fan[2], m_fan[1], m_fan[0]};
    endfunction

    function automatic logic [63:0] dut_fan();
        return {fan_out7, fan_out6, fan_out5, fan_out4, fan_out3, fan_out2, fan_out1, fan_out0};
    endfunction

    // One clock edge; model advances with the inputs seen at that edge, then
    // outputs are left settled 1 time unit after the edge.
    task automatic step();
        logic       rdy;
        logic [7:0] op, fi;
        logic [2:0] tgt_before;
        rdy = instruction_ready; op = instruction_in; fi = fan_in;
        tgt_before = exp_tgt();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) m_fan[i] = (i == int'(tgt_before)) ? fi : 8'h00;
        if (m_age == 0) begin
            if (rdy) begin m_age = 1; m_op = op; end
        end else if (m_age == 1) m_age = 2;
        else m_age = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; instruction_ready = 1'b1; instruction_in = 8'hA9; fan_in = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        if (dut_ctrl() !== {8'h00, 7'd0, 3'd6, 3'd4, 3'd6, 3'd4, 1'b0}) begin
            $display("FAIL reset_ctrl: got %h want %h", dut_ctrl(),
                     {8'h00, 7'd0, 3'd6, 3'd4, 3'd6, 3'd4, 1'b0});
            errors++;
        end
        checks++;
        if (dut_fan() !== 64'd0) begin
            $display("FAIL reset_fan: got %h want 0", dut_fan()); errors++;
        end
        checks++;
        instruction_ready = 1'b0;
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_lda();
        instruction_in = 8'hA9; instruction_ready = 1'b1; fan_in = 8'h11;
        step();
        instruction_ready = 1'b0;
        if (we !== 7'b0000100 || source_selector_0 !== 3'd4 || target_selector_0 !== 3'd1
            || opp !== 8'hA9) begin
            $display("FAIL lda_exec: got we=%b src=%0d tgt=%0d opp=%h want we=0000100 src=4 tgt=1 opp=a9",
                     we, source_selector_0, target_selector_0, opp);
            errors++;
        end
        checks++;
        for (int c = 0; c < 2; c++) begin
            step();
            if (dut_ctrl() !== exp_ctrl()) begin
                $display("FAIL lda_cycle%0d: got %h want %h", c + 2, dut_ctrl(), exp_ctrl());
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_sta_fan();
        instruction_in = 8'h85; instruction_ready = 1'b1; fan_in = 8'h04;
        step();
        instruction_ready = 1'b0;
        if (dut_ctrl() !== exp_ctrl()) begin
            $display("FAIL sta_exec: got %h want %h", dut_ctrl(), exp_ctrl()); errors++;
        end
        checks++;
        step();
        if (dut_fan() !== {16'h0000, 8'h04, 40'h0}) begin
            $display("FAIL sta_fan: got %h want %h", dut_fan(), {16'h0000, 8'h04, 40'h0});
            errors++;
        end
        checks++;
        step();
        if (dut_fan() !== exp_fan()) begin
            $display("FAIL sta_fan_idle: got %h want %h", dut_fan(), exp_fan()); errors++;
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        instruction_in = 8'hA2; instruction_ready = 1'b1; fan_in = 8'h33;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) instruction_ready = 1'b0;
            step();
            if (c == 0) instruction_in = 8'h8A;
            if (dut_ctrl() !== exp_ctrl() || dut_fan() !== exp_fan()) begin
                $display("FAIL b2b_cycle%0d: got %h/%h want %h/%h", c,
                         dut_ctrl(), dut_fan(), exp_ctrl(), exp_fan());
                errors++;
            end
            checks++;
        end
        if (opp !== 8'h8A) begin
            $display("FAIL b2b_second_opp: got %h want 8a", opp); errors++;
        end
        checks++;
    endtask

    task automatic test_undefined();
        instruction_in = 8'hFF; instruction_ready = 1'b1; fan_in = 8'h77;
        step();
        instruction_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) step();
            if (dut_ctrl() !== exp_ctrl()) begin
                $display("FAIL undef_cycle%0d: got %h want %h", c, dut_ctrl(), exp_ctrl());
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            instruction_ready = 1'($urandom_range(0, 1));
            instruction_in = ($urandom_range(0, 9) < 7) ? defined_ops[$urandom_range(0, 11)]
                                                         : 8'($urandom);
            fan_in = 8'($urandom);
            step();
            if (dut_ctrl() !== exp_ctrl() || dut_fan() !== exp_fan()) begin
                $display("FAIL random_cycle%0d: got %h/%h want %h/%h", c,
                         dut_ctrl(), dut_fan(), exp_ctrl(), exp_fan());
                errors++;
            end
            checks++;
            if (phi1 !== 1'b0 || phi2 !== 1'b1) begin
                $display("FAIL phase_high%0d: got phi1=%b phi2=%b want 0 1", c, phi1, phi2);
                errors++;
            end
            checks++;
        end
        instruction_ready = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_phases();
        @(negedge clk);
        #1;
        if (phi1 !== 1'b1 || phi2 !== 1'b0) begin
            $display("FAIL phase_low: got phi1=%b phi2=%b want 1 0", phi1, phi2); errors++;
        end
        checks++;
    endtask

    task automatic test_async_reset();
        instruction_in = 8'h85; instruction_ready = 1'b1; fan_in = 8'h99;
        step();
        instruction_ready = 1'b0;
        if (we !== 7'b1000000) begin
            $display("FAIL areset_pre: got we=%b want 1000000", we); errors++;
        end
        checks++;
        #2 reset_n = 1'b0;
        #1;
        if (we !== 7'd0 || source_selector_0 !== 3'd6 || target_selector_0 !== 3'd4
            || instruction_done !== 1'b0) begin
            $display("FAIL areset_immediate: got we=%b src=%0d tgt=%0d done=%b want 0 6 4 0",
                     we, source_selector_0, target_selector_0, instruction_done);
            errors++;
        end
        checks++;
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (dut_ctrl() !== exp_ctrl() || instruction_done !== 1'b0) begin
                $display("FAIL areset_after%0d: got %h want %h", c, dut_ctrl(), exp_ctrl());
                errors++;
            end
            checks++;
        end
    endtask

    initial begin
        init_table();
        model_reset();
        reset_n = 1'b0; instruction_ready = 1'b0; instruction_in = 8'h00; fan_in = 8'h00;
        test_reset();
        test_lda();
        test_sta_fan();
        test_back_to_back();
        test_undefined();
        test_phases();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_route_unit.md
Name: decode_route_unit

Overview:
- Control block of the 6502-style core: clock phase generation, single-path instruction decoding, and a registered 1-to-8 data fan-out.
- Sits between the fetcher and the register file.
- Takes an opcode with a ready strobe; drives register write enables and mux/fan selectors for one execute cycle, then pulses done.
- Routes a data byte to one of eight destinations selected by the decoded target.

Parameters:
- REG_WIDTH, 8, data/opcode width.
- WE_WIDTH, 7, write-enable vector width. Bit order: 0 PC, 1 SP, 2 ADD, 3 X, 4 Y, 5 STAT, 6 DOUT.

Ports:
- clk  in  1  sole clock (phi0); all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- phi1  out  1  phase 1 clock = ~clk, combinational.
- phi2  out  1  phase 2 clock = clk, combinational.
- instruction_in  in  REG_WIDTH  opcode from fetcher.
- instruction_ready  in  1  opcode valid strobe.
- opp  out  REG_WIDTH  latched opcode being executed.
- we  out  WE_WIDTH  register/memory write enables.
- source_selector_0, target_selector_0  out  3  path-0 mux source / fan target.
- source_selector_1, target_selector_1  out  3  path-1 selectors (reserved).
- instruction_done  out  1  one-cycle completion pulse.
- fan_in  in  REG_WIDTH  data to route.
- fan_out0..fan_out7  out  REG_WIDTH each  routed data.

Behaviour:
- Source encoding: 0 PC, 1 ADD, 2 X, 3 Y, 4 IMM, 5 MEM, 6 ZERO, 7 FETCH.
- Target encoding: 0 PC, 1 ADD, 2 X, 3 Y, 4 NONE, 5 MEM, 6 ALU, 7 FETCH.
- Idle outputs: we=0, source=6, target=4 on both paths.
- Reset (async, while reset_n=0): state IDLE, opp=0, we=0, selectors at idle, instruction_done=0, all fan_out=0.
- FSM states: IDLE, EXEC, DONE.
- IDLE: on rising edge with instruction_ready=1, latch instruction_in into opp and go to EXEC.
- EXEC (exactly one cycle): we and path-0 selectors driven per the opcode table; next state DONE.
- DONE (one cycle): instruction_done=1, we=0, selectors idle; next state IDLE.
- Latency: ready sampled at edge N; controls valid cycle N+1; done high cycle N+2. Next accept earliest at edge N+3.
- instruction_ready is ignored in EXEC and DONE.
- Decode outputs are registered, so they change only on clock edges.
- Opcode table (src -> tgt, we bit):
  - A9 LDA#: 4->1, ADD
  - A5 LDA zpg: 5->1, ADD
  - A2 LDX#: 4->2, X
  - A0 LDY#: 4->3, Y
  - 85 STA zpg: 1->5, DOUT
  - 86 STX zpg: 2->5, DOUT
  - 84 STY zpg: 3->5, DOUT
  - AA TAX: 1->2, X
  - A8 TAY: 1->3, Y
  - 8A TXA: 2->1, ADD
  - 98 TYA: 3->1, ADD
  - EA NOP, and any undefined opcode: idle selectors, we=0, still passes through EXEC/DONE with a done pulse.
- Path 1 held at idle for all opcodes.
- Fan stage: every rising edge, fan_out[target_selector_0] <= fan_in; all other fan_out <= 0. Target 4 therefore clears all outputs except fan_out4.
- Fan output reflects the selector registered in the previous cycle: in EXEC the selector is decoded, and data lands at the edge ending EXEC.
- Reset asserted mid-instruction aborts immediately; no done pulse for that instruction.
- we is never nonzero outside EXEC.

Test Plan:
- Reset: hold reset_n=0 with clk toggling and instruction_ready=1 -> we=0, src/tgt=6/4, done=0, all fan_out=00.
- LDA#: instruction_in=A9 with ready at edge N -> cycle N+1: we=0000100b, src0=4, tgt0=1, opp=A9. Cycle N+2: done=1, we=0. Cycle N+3: idle.
- STA zpg with fan_in=04 -> EXEC: we[6]=1, src0=1, tgt0=5. Next cycle: fan_out5=04, others 00.
- Back-to-back A2 then 8A, ready held high -> two separate EXEC/DONE sequences (X then ADD), second accepted only after the first done. Ready in busy states ignored.
- Undefined opcode FF -> EXEC with we=0 and idle selectors, done pulse at N+2.
- Async reset asserted during EXEC of 85 -> we=0 and selectors idle without waiting for a clock edge; no done pulse. phi1 always equals ~clk and phi2 equals clk.
